// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared lane-state type and round-robin pointer helper
package mem_responder_pkg;
  typedef enum logic [1:0] {LANE_IDLE, LANE_READ_DONE, LANE_WRITE_DONE} lane_state_e;
  function automatic int unsigned wrap_next(int unsigned i, int unsigned n);
    return (i + 1) % n;
  endfunction
endpackage

// File: rtl/lane_mem_responder_if.sv
// lane_mem_responder_if: per-warp lane request/response bundle
interface lane_mem_responder_if #(
  parameter int DATA_MEM_ADDR_BITS = 8,
  parameter int DATA_MEM_DATA_BITS = 8,
  parameter int THREADS_PER_BLOCK = 4
);
  logic [THREADS_PER_BLOCK-1:0] data_mem_1_read_valid, data_mem_2_read_valid;
  logic [THREADS_PER_BLOCK-1:0][DATA_MEM_ADDR_BITS-1:0] data_mem_1_read_address, data_mem_2_read_address;
  logic [THREADS_PER_BLOCK-1:0] data_mem_1_read_ready, data_mem_2_read_ready;
  logic [THREADS_PER_BLOCK-1:0][DATA_MEM_DATA_BITS-1:0] data_mem_1_read_data, data_mem_2_read_data;
  logic [THREADS_PER_BLOCK-1:0] data_mem_1_write_valid, data_mem_2_write_valid;
  logic [THREADS_PER_BLOCK-1:0][DATA_MEM_ADDR_BITS-1:0] data_mem_1_write_address, data_mem_2_write_address;
  logic [THREADS_PER_BLOCK-1:0][DATA_MEM_DATA_BITS-1:0] data_mem_1_write_data, data_mem_2_write_data;
  logic [THREADS_PER_BLOCK-1:0] data_mem_1_write_ready, data_mem_2_write_ready;
  modport master (
    output data_mem_1_read_valid, data_mem_2_read_valid, data_mem_1_read_address, data_mem_2_read_address,
    output data_mem_1_write_valid, data_mem_2_write_valid, data_mem_1_write_address, data_mem_2_write_address,
    output data_mem_1_write_data, data_mem_2_write_data,
    input data_mem_1_read_ready, data_mem_2_read_ready, data_mem_1_read_data, data_mem_2_read_data,
    input data_mem_1_write_ready, data_mem_2_write_ready
  );
  modport slave (
    input data_mem_1_read_valid, data_mem_2_read_valid, data_mem_1_read_address, data_mem_2_read_address,
    input data_mem_1_write_valid, data_mem_2_write_valid, data_mem_1_write_address, data_mem_2_write_address,
    input data_mem_1_write_data, data_mem_2_write_data,
    output data_mem_1_read_ready, data_mem_2_read_ready, data_mem_1_read_data, data_mem_2_read_data,
    output data_mem_1_write_ready, data_mem_2_write_ready
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant of the first request at or above ptr, wrapping
module rr_arbiter #(
  parameter int N = 8,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);
  logic found;
  logic [PW-1:0] idx;
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/lane_mem_responder.sv
// lane_mem_responder: single-port data memory shared by two warps of lanes, one round-robin access per cycle
module lane_mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DATA_MEM_ADDR_BITS = 8,
  parameter int DATA_MEM_DATA_BITS = 8,
  parameter int THREADS_PER_BLOCK = 4
) (
  input  logic clk,
  input  logic reset,
  lane_mem_responder_if.slave bus,
  input  logic host_write_en,
  input  logic [DATA_MEM_ADDR_BITS-1:0] host_address,
  input  logic [DATA_MEM_DATA_BITS-1:0] host_write_data,
  output logic [DATA_MEM_DATA_BITS-1:0] host_read_data
);
  localparam int T = THREADS_PER_BLOCK;
  localparam int L = 2 * T;
  localparam int IW = $clog2(L);
  localparam int AW = DATA_MEM_ADDR_BITS;
  localparam int DW = DATA_MEM_DATA_BITS;
  logic [DW-1:0] mem [2**AW];
  logic [L-1:0] rd_valid, wr_valid, req, grant, read_ready, write_ready;
  logic [L-1:0][AW-1:0] rd_addr, wr_addr;
  logic [L-1:0][DW-1:0] wr_data, read_data;
  lane_state_e state [L];
  logic [IW-1:0] rr_ptr, g_idx;
  logic g_any, g_read, g_write;
  logic [DW-1:0] rd_q;
  assign rd_valid = {bus.data_mem_2_read_valid, bus.data_mem_1_read_valid};
  assign wr_valid = {bus.data_mem_2_write_valid, bus.data_mem_1_write_valid};
  assign rd_addr = {bus.data_mem_2_read_address, bus.data_mem_1_read_address};
  assign wr_addr = {bus.data_mem_2_write_address, bus.data_mem_1_write_address};
  assign wr_data = {bus.data_mem_2_write_data, bus.data_mem_1_write_data};
  assign bus.data_mem_1_read_ready = read_ready[T-1:0];
  assign bus.data_mem_2_read_ready = read_ready[L-1:T];
  assign bus.data_mem_1_write_ready = write_ready[T-1:0];
  assign bus.data_mem_2_write_ready = write_ready[L-1:T];
  assign bus.data_mem_1_read_data = read_data[T-1:0];
  assign bus.data_mem_2_read_data = read_data[L-1:T];
  // host backdoor writes and reset both suppress lane grants so the port stays single-access
  always_comb
    for (int i = 0; i < L; i++)
      req[i] = !reset && !host_write_en && state[i] == LANE_IDLE && (rd_valid[i] || wr_valid[i]);
  rr_arbiter #(.N(L), .PW(IW)) u_arb (.req(req), .ptr(rr_ptr), .grant(grant));
  always_comb begin
    g_idx = '0;
    for (int i = 0; i < L; i++)
      if (grant[i]) g_idx = IW'(i);
  end
  assign g_any = |grant;
  assign g_read = g_any && rd_valid[g_idx];
  assign g_write = g_any && !rd_valid[g_idx];
  assign rd_q = mem[rd_addr[g_idx]];
  assign host_read_data = mem[host_address];
  always_ff @(posedge clk)
    if (host_write_en) mem[host_address] <= host_write_data;
    else if (g_write) mem[wr_addr[g_idx]] <= wr_data[g_idx];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rr_ptr <= '0;
      read_ready <= '0;
      write_ready <= '0;
      read_data <= '0;
      for (int i = 0; i < L; i++) state[i] <= LANE_IDLE;
    end else begin
      if (g_any) rr_ptr <= IW'(wrap_next(32'(g_idx), L));
      for (int i = 0; i < L; i++)
        case (state[i])
          LANE_IDLE:
            if (grant[i]) begin
              state[i] <= rd_valid[i] ? LANE_READ_DONE : LANE_WRITE_DONE;
              read_ready[i] <= rd_valid[i];
              write_ready[i] <= !rd_valid[i];
              if (g_read) read_data[i] <= rd_q;
            end
          LANE_READ_DONE:
            if (!rd_valid[i]) begin
              state[i] <= LANE_IDLE;
              read_ready[i] <= 1'b0;
            end
          LANE_WRITE_DONE:
            if (!wr_valid[i]) begin
              state[i] <= LANE_IDLE;
              write_ready[i] <= 1'b0;
            end
          default: state[i] <= LANE_IDLE;
        endcase
    end
endmodule

// File: tb/tb_lane_mem_responder.sv
// tb_lane_mem_responder: directed stimulus with a ready-edge scoreboard for lane_mem_responder
module tb_lane_mem_responder;
  typedef struct {int lane; int kind; logic [7:0] data; int cyc;} ev_t;
  localparam int RR = 0, WR = 1, RF = 2, WF = 3;
  logic clk = 1'b0, reset = 1'b1;
  logic host_write_en = 1'b0;
  logic [7:0] host_address = '0, host_write_data = '0, host_read_data;
  logic [7:0] rrdy, wrdy, prev_r = '0, prev_w = '0;
  logic [7:0][7:0] rdat, prev_d = '0;
  int cyc = 0, n_vec = 0, n_err = 0;
  ev_t q[$];
  lane_mem_responder_if #(.DATA_MEM_ADDR_BITS(8), .DATA_MEM_DATA_BITS(8), .THREADS_PER_BLOCK(4)) bus ();
  lane_mem_responder #(.DATA_MEM_ADDR_BITS(8), .DATA_MEM_DATA_BITS(8), .THREADS_PER_BLOCK(4)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .host_write_en(host_write_en), .host_address(host_address),
    .host_write_data(host_write_data), .host_read_data(host_read_data)
  );
  assign rrdy = {bus.data_mem_2_read_ready, bus.data_mem_1_read_ready};
  assign wrdy = {bus.data_mem_2_write_ready, bus.data_mem_1_write_ready};
  assign rdat = {bus.data_mem_2_read_data, bus.data_mem_1_read_data};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_rd(int lane, logic v, logic [7:0] a);
    if (lane < 4) begin
      bus.data_mem_1_read_valid[lane] = v;
      bus.data_mem_1_read_address[lane] = a;
    end else begin
      bus.data_mem_2_read_valid[lane-4] = v;
      bus.data_mem_2_read_address[lane-4] = a;
    end
  endtask
  task automatic set_wr(int lane, logic v, logic [7:0] a, logic [7:0] d);
    if (lane < 4) begin
      bus.data_mem_1_write_valid[lane] = v;
      bus.data_mem_1_write_address[lane] = a;
      bus.data_mem_1_write_data[lane] = d;
    end else begin
      bus.data_mem_2_write_valid[lane-4] = v;
      bus.data_mem_2_write_address[lane-4] = a;
      bus.data_mem_2_write_data[lane-4] = d;
    end
  endtask
  task automatic expect_ev(int lane, int kind, logic [7:0] d, int c);
    ev_t e;
    e.lane = lane; e.kind = kind; e.data = d; e.cyc = c;
    q.push_back(e);
  endtask
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic host_wr(logic [7:0] a, logic [7:0] d);
    host_write_en = 1'b1; host_address = a; host_write_data = d;
    tick();
    host_write_en = 1'b0;
  endtask
  task automatic mon_ev(int lane, int kind, logic [7:0] d);
    ev_t e;
    n_vec++;
    if (q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: lane %0d kind %0d data %0h cycle %0d, none expected", lane, kind, d, cyc);
    end else begin
      e = q.pop_front();
      if (e.lane != lane || e.kind != kind || e.cyc != cyc || (kind == RR && e.data !== d)) begin
        n_err++;
        $display("FAIL ready_event: got lane %0d kind %0d data %0h cycle %0d, expected lane %0d kind %0d data %0h cycle %0d",
                 lane, kind, d, cyc, e.lane, e.kind, e.data, e.cyc);
      end
    end
  endtask
  // every ready edge must match the next scoreboard entry; held read data must not move
  always @(negedge clk) begin
    if (!reset)
      for (int i = 0; i < 8; i++) begin
        if (rrdy[i] !== prev_r[i]) mon_ev(i, rrdy[i] ? RR : RF, rdat[i]);
        else if (rrdy[i]) begin
          n_vec++;
          if (rdat[i] !== prev_d[i]) begin
            n_err++;
            $display("FAIL hold_data lane %0d: got %0h expected %0h", i, rdat[i], prev_d[i]);
          end
        end
        if (wrdy[i] !== prev_w[i]) mon_ev(i, wrdy[i] ? WR : WF, 8'h00);
      end
    prev_r = rrdy; prev_w = wrdy; prev_d = rdat;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int c;
    bus.data_mem_1_read_valid = '0; bus.data_mem_2_read_valid = '0;
    bus.data_mem_1_write_valid = '0; bus.data_mem_2_write_valid = '0;
    bus.data_mem_1_read_address = '0; bus.data_mem_2_read_address = '0;
    bus.data_mem_1_write_address = '0; bus.data_mem_2_write_address = '0;
    bus.data_mem_1_write_data = '0; bus.data_mem_2_write_data = '0;
    tick(); tick();
    chk("reset_read_ready", rrdy, 0);
    chk("reset_write_ready", wrdy, 0);
    chk("reset_read_data", rdat, 0);
    host_wr(8'h10, 8'hAB);
    host_address = 8'h10;
    #1 chk("host_rd_10", host_read_data, 8'hAB);
    reset = 1'b0;
    tick();
    c = cyc;
    set_rd(0, 1'b1, 8'h10);
    expect_ev(0, RR, 8'hAB, c + 1);
    tick(); tick(); tick();
    set_rd(0, 1'b0, 8'h10);
    expect_ev(0, RF, 8'h00, c + 4);
    tick(); tick();
    for (int i = 0; i < 8; i++) host_wr(8'h40 + 8'(i), 8'h80 + 8'(3 * i));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    c = cyc;
    for (int i = 0; i < 8; i++) begin
      set_rd(i, 1'b1, 8'h40 + 8'(i));
      expect_ev(i, RR, 8'h80 + 8'(3 * i), c + 1 + i);
    end
    repeat (9) tick();
    for (int i = 0; i < 8; i++) begin
      set_rd(i, 1'b0, 8'h00);
      expect_ev(i, RF, 8'h00, c + 10);
    end
    tick(); tick();
    c = cyc;
    set_rd(6, 1'b1, 8'h46);
    set_rd(0, 1'b1, 8'h40);
    expect_ev(0, RR, 8'h80, c + 1);
    expect_ev(6, RR, 8'h92, c + 2);
    repeat (3) tick();
    set_rd(0, 1'b0, 8'h00); set_rd(6, 1'b0, 8'h00);
    expect_ev(0, RF, 8'h00, c + 4);
    expect_ev(6, RF, 8'h00, c + 4);
    tick(); tick();
    c = cyc;
    set_wr(7, 1'b1, 8'h20, 8'h5A);
    expect_ev(7, WR, 8'h00, c + 1);
    tick();
    set_wr(7, 1'b0, 8'h00, 8'h00);
    expect_ev(7, WF, 8'h00, c + 2);
    tick();
    set_rd(1, 1'b1, 8'h20);
    expect_ev(1, RR, 8'h5A, c + 3);
    tick();
    set_rd(1, 1'b0, 8'h00);
    expect_ev(1, RF, 8'h00, c + 4);
    tick(); tick();
    host_address = 8'h20;
    #1 chk("host_rd_20", host_read_data, 8'h5A);
    tick();
    c = cyc;
    set_rd(2, 1'b1, 8'h10);
    set_wr(2, 1'b1, 8'h30, 8'h77);
    expect_ev(2, RR, 8'hAB, c + 1);
    tick();
    set_rd(2, 1'b0, 8'h00);
    expect_ev(2, RF, 8'h00, c + 2);
    expect_ev(2, WR, 8'h00, c + 3);
    tick(); tick();
    set_wr(2, 1'b0, 8'h00, 8'h00);
    expect_ev(2, WF, 8'h00, c + 4);
    tick(); tick();
    host_address = 8'h30;
    #1 chk("host_rd_30", host_read_data, 8'h77);
    tick();
    c = cyc;
    host_write_en = 1'b1; host_address = 8'h50; host_write_data = 8'h11;
    set_rd(2, 1'b1, 8'h50);
    tick();
    host_write_data = 8'h22;
    tick();
    host_write_data = 8'h33;
    tick();
    host_write_en = 1'b0;
    expect_ev(2, RR, 8'h33, c + 4);
    tick();
    set_rd(2, 1'b0, 8'h00);
    expect_ev(2, RF, 8'h00, c + 5);
    tick(); tick();
    c = cyc;
    set_rd(1, 1'b1, 8'h20);
    set_rd(5, 1'b1, 8'h10);
    expect_ev(5, RR, 8'hAB, c + 1);
    expect_ev(1, RR, 8'h5A, c + 2);
    tick(); tick(); tick();
    chk("pre_reset_ready_1_5", {rrdy[5], rrdy[1]}, 2'b11);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_read_ready", rrdy, 0);
    chk("async_reset_write_ready", wrdy, 0);
    chk("async_reset_read_data", rdat, 0);
    set_rd(1, 1'b0, 8'h00); set_rd(5, 1'b0, 8'h00);
    host_address = 8'h20;
    #1 chk("reset_mem_20", host_read_data, 8'h5A);
    host_address = 8'h10;
    #1 chk("reset_mem_10", host_read_data, 8'hAB);
    tick();
    reset = 1'b0;
    c = cyc;
    set_rd(3, 1'b1, 8'h30);
    set_rd(1, 1'b1, 8'h20);
    expect_ev(1, RR, 8'h5A, c + 1);
    expect_ev(3, RR, 8'h77, c + 2);
    repeat (3) tick();
    set_rd(1, 1'b0, 8'h00); set_rd(3, 1'b0, 8'h00);
    expect_ev(1, RF, 8'h00, c + 4);
    expect_ev(3, RF, 8'h00, c + 4);
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    tick();
    chk("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
